// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-vote bit sampling, optional parity,
// one or two stop bits, and a single-entry output buffer with overrun flag.
module uart_rx_ovs #(
  parameter int WIDTH = 8,
  parameter int OVS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             rx,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_err,
  output logic             stop_err,
  output logic             overrun_err
);

  localparam int TW = $clog2(OVS);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] T_S0   = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVS / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_END  = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic             rx_m, rx_s;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             s0, s1;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic             serr;
  logic [1:0]       mode_l;
  logic             two_l;
  logic             stop_idx;
  logic             done;
  logic [WIDTH-1:0] frame_data;
  logic             frame_perr;
  logic             frame_serr;

  logic vote, par_en, perr_calc;
  logic at_s0, at_s1, at_s2, at_end;

  assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign par_en    = (mode_l == 2'b01) || (mode_l == 2'b10);
  assign perr_calc = (mode_l == 2'b01) ? (^shreg ^ par_bit) :
                     (mode_l == 2'b10) ? ~(^shreg ^ par_bit) : 1'b0;
  assign at_s0     = (tick_cnt == T_S0);
  assign at_s1     = (tick_cnt == T_S1);
  assign at_s2     = (tick_cnt == T_S2);
  assign at_end    = (tick_cnt == T_END);

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM: tick-driven bit timing, three-sample vote, registered frame result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      par_bit    <= 1'b0;
      serr       <= 1'b0;
      mode_l     <= 2'b00;
      two_l      <= 1'b0;
      stop_idx   <= 1'b0;
      done       <= 1'b0;
      frame_data <= '0;
      frame_perr <= 1'b0;
      frame_serr <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) begin
        if (state == IDLE) begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            serr     <= 1'b0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
            mode_l   <= parity_mode;
            two_l    <= two_stop;
          end
        end else begin
          tick_cnt <= at_end ? '0 : tick_cnt + 1'b1;
          if (at_s0) s0 <= rx_s;
          if (at_s1) s1 <= rx_s;
          // Votes act on the third sample; period-end transitions act at the last tick.
          if (at_s2) begin
            case (state)
              START:  if (vote) state <= IDLE;
              DATA:   shreg <= {vote, shreg[WIDTH-1:1]};
              PARITY: par_bit <= vote;
              STOP: begin
                if (!vote) serr <= 1'b1;
                if (stop_idx == two_l) begin
                  state      <= IDLE;
                  done       <= 1'b1;
                  frame_data <= shreg;
                  frame_perr <= perr_calc;
                  frame_serr <= serr | ~vote;
                end else begin
                  stop_idx <= 1'b1;
                end
              end
              default: ;
            endcase
          end
          if (at_end) begin
            case (state)
              START: state <= DATA;
              DATA: begin
                if (bit_cnt == B_LAST) state <= par_en ? PARITY : STOP;
                else bit_cnt <= bit_cnt + 1'b1;
              end
              PARITY: state <= STOP;
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Single-entry output buffer: accept on empty or same-cycle handshake, else overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      stop_err    <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= frame_data;
        parity_err <= frame_perr;
        stop_err   <= frame_serr;
        rx_valid   <= 1'b1;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule
